// File: rtl/byte_dma_pkg.sv
// Shared types and constants for the byte-stream DMA writer.
package byte_dma_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STRIDE    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } dma_wr_state_t;

endpackage

// File: rtl/byte_packer.sv
// Lane counter and 4x8 assembly register; packing order set by BYTE_DMA_WR_BIG_ENDIAN_EN.
module byte_packer
  import byte_dma_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  data,
  input  logic        accept,
  input  logic        clear,
  output logic [1:0]  lane,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BYTES_PER_WORD-1:0][7:0] lanes_q;
  logic [1:0]                     slot;

`ifdef BYTE_DMA_WR_BIG_ENDIAN_EN
  assign slot = 2'(BYTES_PER_WORD - 1) - lane;
`else
  assign slot = lane;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn || clear) begin
      lane    <= '0;
      lanes_q <= '0;
    end else if (accept) begin
      lanes_q[slot] <= data;
      lane          <= lane + 2'd1;
    end
  end

  assign word      = lanes_q;
  assign word_full = accept && (lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/byte_stream_dma_writer.sv
// Packs an 8-bit stream into 32-bit words and writes them to memory from the RCC DMA base.
// Optional BYTE_DMA_WR_BIG_ENDIAN_EN selects big-endian packing (see byte_packer).
module byte_stream_dma_writer
  import byte_dma_pkg::*;
#(
  parameter int LEN_W  = 6,
  parameter int BCNT_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_start,
  input  logic [15:0]       i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0]       i_RCC_DMA_ADDR_LOW,
  input  logic [LEN_W-1:0]  i_RCC_BUFFER_LENGTH,
  input  logic [7:0]        i_serialized_input,
  input  logic              i_serialized_input_valid,
  output logic              o_ready,
  output logic [31:0]       mem_WR_addr,
  output logic              mem_write_flag,
  output logic [31:0]       HWDATA_toMem,
  output logic [1:0]        o_Serialize_Counter,
  output logic [BCNT_W-1:0] o_Bytes_Counter,
  output logic              o_busy,
  output logic              o_Done
);

  dma_wr_state_t    state;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wordcnt;
  logic [LEN_W-1:0] wordcnt_nxt;
  logic [31:0]      packed_word;
  logic             accept;
  logic             word_full;

  assign accept      = i_serialized_input_valid && o_ready;
  assign wordcnt_nxt = wordcnt + LEN_W'(1);

  byte_packer u_packer (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .data      (i_serialized_input),
    .accept    (accept),
    .clear     (state == ST_IDLE),
    .lane      (o_Serialize_Counter),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state           <= ST_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      wordcnt         <= '0;
      o_Bytes_Counter <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_Bytes_Counter <= '0;
          wordcnt         <= '0;
          if (i_start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          base_q <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
          len_q  <= i_RCC_BUFFER_LENGTH;
          state  <= (i_RCC_BUFFER_LENGTH == '0) ? ST_DONE : ST_COLLECT;
        end
        ST_COLLECT: begin
          if (accept) begin
            o_Bytes_Counter <= o_Bytes_Counter + BCNT_W'(1);
            if (word_full) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wordcnt <= wordcnt_nxt;
          state   <= (wordcnt_nxt == len_q) ? ST_DONE : ST_COLLECT;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Memory-port drive is decoded from state so address/data read zero outside the strobe.
  assign o_ready        = (state == ST_COLLECT);
  assign mem_write_flag = (state == ST_WRITE);
  assign mem_WR_addr    = mem_write_flag ? base_q + 32'(wordcnt) * 32'(ADDR_STRIDE) : 32'h0;
  assign HWDATA_toMem   = mem_write_flag ? packed_word : 32'h0;
  assign o_busy         = (state != ST_IDLE);
  assign o_Done         = (state == ST_DONE);

endmodule

// File: tb/tb_byte_stream_dma_writer.sv
// Directed bench with a queue-based write model checked every cycle.
module tb_byte_stream_dma_writer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] addr_hi = '0;
  logic [15:0] addr_lo = '0;
  logic [5:0]  buf_len = '0;
  logic [7:0]  din = '0;
  logic        dvld = 1'b0;
  logic        o_ready, mem_write_flag, o_busy, o_Done;
  logic [31:0] mem_WR_addr, HWDATA_toMem;
  logic [1:0]  o_Serialize_Counter;
  logic [15:0] o_Bytes_Counter;

  byte_stream_dma_writer #(.LEN_W(6), .BCNT_W(16)) dut (
    .HCLK                     (HCLK),
    .HRESETn                  (HRESETn),
    .i_start                  (i_start),
    .i_RCC_DMA_ADDR_HIGH      (addr_hi),
    .i_RCC_DMA_ADDR_LOW       (addr_lo),
    .i_RCC_BUFFER_LENGTH      (buf_len),
    .i_serialized_input       (din),
    .i_serialized_input_valid (dvld),
    .o_ready                  (o_ready),
    .mem_WR_addr              (mem_WR_addr),
    .mem_write_flag           (mem_write_flag),
    .HWDATA_toMem             (HWDATA_toMem),
    .o_Serialize_Counter      (o_Serialize_Counter),
    .o_Bytes_Counter          (o_Bytes_Counter),
    .o_busy                   (o_busy),
    .o_Done                   (o_Done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [15:0] bytes_at_done = '0;
  wr_t         exp_q[$];
  wr_t         log_q[$];
  wr_t         cur;
  logic [7:0]  src_q[$];

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
`ifdef BYTE_DMA_WR_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Compare process: every write must match the head of the model queue.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (mem_write_flag) begin
        log_q.push_back('{mem_WR_addr, HWDATA_toMem});
        chk("ready_in_write", 32'(o_ready), 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got addr %h data %h want none", mem_WR_addr, HWDATA_toMem);
        end else begin
          cur = exp_q.pop_front();
          chk("wr_addr", mem_WR_addr, cur.a);
          chk("wr_data", HWDATA_toMem, cur.d);
        end
      end else begin
        chk("idle_addr", mem_WR_addr, 32'h0);
        chk("idle_data", HWDATA_toMem, 32'h0);
      end
      if (o_Done) begin
        done_cnt++;
        bytes_at_done = o_Bytes_Counter;
      end
    end
  end

  task automatic model_push(input logic [31:0] base, input int l);
    for (int w = 0; w < l; w++)
      exp_q.push_back('{(base & 32'hFFFF_FFFC) + 32'(4 * w),
                        pack(src_q[4*w], src_q[4*w+1], src_q[4*w+2], src_q[4*w+3])});
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [5:0] l);
    addr_hi = base[31:16];
    addr_lo = base[15:0];
    buf_len = l;
    i_start = 1'b1;
    @(posedge HCLK); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input int n, input bit throttle);
    int  i = 0;
    int  guard = 0;
    bit  phase = 1'b1;
    bit  acc;
    while (i < n && guard < 1000) begin
      din  = src_q[i];
      dvld = throttle ? phase : 1'b1;
      phase = ~phase;
      @(negedge HCLK);
      acc = dvld && o_ready;
      @(posedge HCLK); #1;
      if (acc) i++;
      guard++;
    end
    dvld = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got %0d bytes want %0d", i, n);
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input int l, input bit throttle);
    int d0 = done_cnt;
    int k = 0;
    model_push(base, l);
    start_xfer(base, 6'(l));
    send(4 * l, throttle);
    while (done_cnt == d0 && k < 20) begin
      @(negedge HCLK);
      k++;
    end
    repeat (3) @(negedge HCLK);
    chk("done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("bytes_at_done", 32'(bytes_at_done), 32'(4 * l));
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("busy_after", 32'(o_busy), 32'h0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_flag", 32'(mem_write_flag), 32'h0);
    chk("rst_addr", mem_WR_addr, 32'h0);
    chk("rst_data", HWDATA_toMem, 32'h0);
    chk("rst_lane", 32'(o_Serialize_Counter), 32'h0);
    chk("rst_bytes", 32'(o_Bytes_Counter), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_done", 32'(o_Done), 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Basic transfer
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    n0 = log_q.size();
    run_xfer(32'h0000_1000, 2, 1'b0);
    chk("basic_nwr", 32'(log_q.size() - n0), 32'd2);
    if (log_q.size() >= n0 + 2) begin
      chk("basic_a0", log_q[n0].a, 32'h0000_1000);
      chk("basic_a1", log_q[n0+1].a, 32'h0000_1004);
`ifdef BYTE_DMA_WR_BIG_ENDIAN_EN
      chk("basic_d0", log_q[n0].d, 32'h1122_3344);
      chk("basic_d1", log_q[n0+1].d, 32'h5566_7788);
`else
      chk("basic_d0", log_q[n0].d, 32'h4433_2211);
      chk("basic_d1", log_q[n0+1].d, 32'h8877_6655);
`endif
    end

    // Zero length: done at cycle 2, no strobe
    n0 = log_q.size();
    addr_hi = 16'h0;
    addr_lo = 16'h0100;
    buf_len = 6'd0;
    i_start = 1'b1;
    @(posedge HCLK); #1;
    i_start = 1'b0;
    chk("zl_load_done", 32'(o_Done), 32'h0);
    chk("zl_load_busy", 32'(o_busy), 32'h1);
    @(posedge HCLK); #1;
    chk("zl_done", 32'(o_Done), 32'h1);
    @(posedge HCLK); #1;
    chk("zl_busy_fall", 32'(o_busy), 32'h0);
    chk("zl_no_write", 32'(log_q.size() - n0), 32'h0);

    // Throttled input
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    n0 = log_q.size();
    run_xfer(32'h0000_2000, 1, 1'b1);
    chk("thr_nwr", 32'(log_q.size() - n0), 32'd1);
`ifndef BYTE_DMA_WR_BIG_ENDIAN_EN
    if (log_q.size() > n0) chk("thr_d0", log_q[n0].d, 32'hD4C3_B2A1);
`endif

    // Address wrap, with an unaligned low address whose bits [1:0] are dropped
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    n0 = log_q.size();
    run_xfer(32'hFFFF_FFFE, 2, 1'b0);
    if (log_q.size() >= n0 + 2) begin
      chk("wrap_a0", log_q[n0].a, 32'hFFFF_FFFC);
      chk("wrap_a1", log_q[n0+1].a, 32'h0000_0000);
    end else begin
      chk("wrap_nwr", 32'(log_q.size() - n0), 32'd2);
    end

    // Reset mid-transfer after two bytes
    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    n0 = log_q.size();
    start_xfer(32'h0000_3000, 6'd1);
    send(2, 1'b0);
    chk("mid_lane", 32'(o_Serialize_Counter), 32'd2);
    chk("mid_bytes", 32'(o_Bytes_Counter), 32'd2);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk("mr_ready", 32'(o_ready), 32'h0);
    chk("mr_flag", 32'(mem_write_flag), 32'h0);
    chk("mr_addr", mem_WR_addr, 32'h0);
    chk("mr_data", HWDATA_toMem, 32'h0);
    chk("mr_lane", 32'(o_Serialize_Counter), 32'h0);
    chk("mr_bytes", 32'(o_Bytes_Counter), 32'h0);
    chk("mr_busy", 32'(o_busy), 32'h0);
    chk("mr_done", 32'(o_Done), 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("mr_no_write", 32'(log_q.size() - n0), 32'h0);
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(32'h0000_4000, 1, 1'b0);
    if (log_q.size() > n0) begin
      chk("after_rst_a", log_q[n0].a, 32'h0000_4000);
`ifdef BYTE_DMA_WR_BIG_ENDIAN_EN
      chk("after_rst_d", log_q[n0].d, 32'h1122_3344);
`else
      chk("after_rst_d", log_q[n0].d, 32'h4433_2211);
`endif
    end else begin
      chk("after_rst_nwr", 32'(log_q.size() - n0), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_stream_dma_writer.md
# byte_stream_dma_writer

Receive-side counterpart of the core system's memory-read-and-serialize path. The block accepts an 8-bit serialized byte stream and packs four bytes into each 32-bit word. It writes the words to external memory through the `ahb3lite_memory` write port, starting at the address given by the RCC DMA registers, for the number of words given by `RCC_BUFFER_LENGTH`. It sits alongside the CPU writer on the memory write port and is selected by top-level switch logic.

## Interface
Parameters:
- `LEN_W`, 6: width of the buffer-length input, in 32-bit words.
- `BCNT_W`, 16: width of the accepted-byte counter.

Ports:
- `HCLK`  in  1  clock. One clock; all logic is on its rising edge.
- `HRESETn`  in  1  reset. Synchronous, active-low.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_RCC_DMA_ADDR_HIGH`  in  16  upper half of the base address.
- `i_RCC_DMA_ADDR_LOW`  in  16  lower half of the base address.
- `i_RCC_BUFFER_LENGTH`  in  LEN_W  number of words to write.
- `i_serialized_input`  in  8  stream byte.
- `i_serialized_input_valid`  in  1  byte valid.
- `o_ready`  out  1  block can accept a byte.
- `mem_WR_addr`  out  32  write address.
- `mem_write_flag`  out  1  one-cycle write strobe.
- `HWDATA_toMem`  out  32  write data.
- `o_Serialize_Counter`  out  2  byte lane of the next byte to be accepted.
- `o_Bytes_Counter`  out  BCNT_W  bytes accepted since the last start.
- `o_busy`  out  1  transfer in progress.
- `o_Done`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, LOAD, COLLECT, WRITE, DONE.
- **IDLE**
  - If `i_start` is high, go to LOAD.
  - Clear `o_Bytes_Counter`, the word counter and the lane counter.
- **LOAD** (one cycle)
  - Latch base = {HIGH, LOW} with bits [1:0] forced to 0, and latch the length.
  - If length == 0, go to DONE; otherwise go to COLLECT.
  - Register values are not re-sampled during the transfer.
- **COLLECT**
  - `o_ready` = 1.
  - A byte is accepted when `valid && o_ready`. Store it in lane `o_Serialize_Counter`, then increment the lane counter (wraps 3→0) and `o_Bytes_Counter`.
  - Acceptance of lane 3 moves the FSM to WRITE.
  - When valid is low, the FSM holds and nothing changes.
- **WRITE** (one cycle)
  - `o_ready` = 0 and `mem_write_flag` = 1.
  - `mem_WR_addr` = base + 4·wordcnt, using 32-bit modulo arithmetic (wraps at 2^32).
  - `HWDATA_toMem` = the packed word.
  - Increment wordcnt. If the new wordcnt == length, go to DONE; otherwise go to COLLECT.
- **DONE** (one cycle)
  - `o_Done` = 1, then go to IDLE.
- `o_busy` = 1 in every state except IDLE.
- `i_start` in any state other than IDLE is ignored.
- A valid byte offered while `o_ready` = 0 is not consumed. The source must hold it until it is accepted.
- `o_Bytes_Counter` wraps modulo 2^BCNT_W.
- Reset mid-transfer:
  - Returns the FSM to IDLE immediately.
  - The partial word is discarded and no write is issued.
  - `mem_write_flag` is low from the next cycle.

## Timing
- Reset values of all outputs are 0. `o_ready` is 0 because the FSM resets to IDLE.
- Start to first possible acceptance: `i_start` at cycle 0, LOAD at cycle 1, COLLECT with `o_ready` = 1 at cycle 2.
- Fourth byte accepted at cycle t → write strobe at cycle t+1 → next byte acceptable at cycle t+2.
- Steady-state throughput is 4 bytes per 5 cycles.
- The last write at cycle t is followed by `o_Done` at cycle t+1. `o_busy` falls at cycle t+2.
- `mem_WR_addr` and `HWDATA_toMem` are driven only while the strobe is high and hold 0 otherwise.
- All outputs are registered or decoded from the FSM state; there is no combinational path from `valid` to any output.

## Configuration
- Macro: `BYTE_DMA_WR_BIG_ENDIAN_EN`.
- Undefined (default), little-endian packing:
  - Lane 0 → [7:0], lane 3 → [31:24].
  - This matches the serializer's byte order.
- Defined, big-endian packing:
  - Lane 0 → [31:24], lane 3 → [7:0].
- The macro changes only the packing; the lane counter and FSM are unaffected.

## Structure
- Shared package `byte_dma_pkg`:
  - FSM state enum `dma_wr_state_t`.
  - `BYTES_PER_WORD` = 4.
  - `ADDR_STRIDE` = 4.
- One sub-module, `byte_packer`:
  - Contains the lane counter and the 4×8 assembly register.
  - Ports: byte, accept, clear, lane out, word out, word_full.
  - The top level holds the FSM, the address/word counters and the memory-port drive.

## Test plan
- **Basic transfer:** base = 0x0000_1000, length = 2, bytes 0x11..0x88 with valid held high.
  - Writes 0x44332211 @ 0x1000 and 0x88776655 @ 0x1004.
  - `o_Done` pulses once and `o_Bytes_Counter` = 8.
- **Zero length:** length = 0, then start.
  - No write strobe; `o_Done` pulses at cycle 2 after start.
- **Throttled input:** valid toggles 1-0-1-0 with length = 1.
  - One write of the correct word; no byte is lost or duplicated.
  - `o_ready` is low during the WRITE cycle.
- **Address wrap:** base = 0xFFFF_FFFC, length = 2.
  - Writes go to 0xFFFF_FFFC, then 0x0000_0000.
- **Reset mid-transfer:** reset asserted after 2 bytes.
  - No write issued; all outputs 0.
  - A new start then completes normally.
- **Big-endian build:** with `BYTE_DMA_WR_BIG_ENDIAN_EN` defined, bytes 0x11, 0x22, 0x33, 0x44.
  - HWDATA = 0x11223344.
